bounded_count_arbiter: RTL
==========================

# bounded_count_arbiter

Round-robin arbiter that shares one bounded step counter between two requesters. Each granted cycle advances the shared index `i` by one and credits the winner's private tally. Granting stops permanently once `i` exceeds `LIMIT`, until reset or `clear`. It sits in front of the bounded-increment datapath and replaces its single `selector` with two arbitrated request lines.

## Interface

Parameters:
- `W`, default 10: width of `i`, `sn0`, `sn1`. `LIMIT+1` must fit in W bits.
- `LIMIT`, default 300: last index value at which a grant is still allowed.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high; forces the reset values immediately.
- `clear`, input, 1: synchronous restart to the reset values; has priority over `req`.
- `req`, input, 2: request vector; bit n is requester n.
- `grant`, output reg, 2: one-hot grant issued at the last edge, or 00.
- `i`, output reg, W: shared index.
- `sn0`, output reg, W: grant count credited to requester 0.
- `sn1`, output reg, W: grant count credited to requester 1.
- `busy`, output, 1: registered `grant != 0`.
- `exhausted`, output, 1: combinational `i > LIMIT`.

## Operation

- Internal state is a round-robin pointer `last` (1 bit, the most recent winner) plus the output registers.
- Reset values (async `rst`, and sync `clear` on the edge):
  - `i`=1, `sn0`=0, `sn1`=0, `grant`=00, `last`=1.
  - Requester 0 therefore wins the first tie.
- Eligibility: a grant is allowed only when `!exhausted`, i.e. `i <= LIMIT`, and `req != 00`.
- Winner selection:
  - `req`=01 gives requester 0; `req`=10 gives requester 1.
  - `req`=11 gives `!last`, so requesters strictly alternate under continuous contention.
- On an eligible edge:
  - `i <= i+1`.
  - `sn_winner <= sn_winner+1`; the other tally holds.
  - `grant <=` one-hot winner.
  - `last <=` winner. The pointer updates on every grant, including uncontested ones.
- On a non-eligible edge: `i`, `sn0`, `sn1` and `last` hold, and `grant <= 00`.
- Implicit states:
  - IDLE: not exhausted, `grant`=00.
  - ACTIVE: `grant` != 00.
  - EXHAUSTED: `i` = `LIMIT+1`.
- State transitions:
  - IDLE to ACTIVE on any request.
  - ACTIVE to IDLE when requests drop.
  - ACTIVE to EXHAUSTED on the grant that sets `i` = `LIMIT+1`.
  - EXHAUSTED is left only via `rst` or `clear`.
- Arithmetic:
  - Unsigned, W bits. No wrap is possible because `i` never exceeds `LIMIT+1`.
  - Each tally is at most `LIMIT`.
- Invariant, checked at every edge: `sn0 + sn1 == i - 1`.
  - Consequence: `exhausted` implies `sn0 + sn1 == LIMIT`.
  - Consequence: `i` is never 0.
- `req` is sampled only at the edge; changes between edges have no effect.

## Timing

- Latency: one cycle.
  - `req` sampled at edge k produces `grant`, `i`, and the tally update visible after edge k.
- `grant` is valid for exactly one cycle per sampled request. A requester that holds `req` keeps receiving grants according to the round-robin rule.
- No back-to-back restriction applies; a lone requester is granted every cycle.
- Exhaustion timing:
  - The edge that writes `i` = `LIMIT+1` still shows that final grant.
  - The next edge drives `grant`=00, whatever `req` is.
- Simultaneous events:
  - `clear` together with an eligible `req`: the clear wins and no grant is recorded.
  - `rst` overrides everything, asynchronously.
- Reset mid-operation: all counts are discarded, with no partial update. The first edge after deassertion behaves as a fresh start.

## Test plan

- Reset: assert `rst` between clock edges.
  - Required: `i`=1, `sn0`=`sn1`=0, `grant`=00, `busy`=0 and `exhausted`=0 immediately, without waiting for an edge.
- Single requester: after reset, hold `req`=01 for 5 edges.
  - Required: `grant`=01 after each edge, then `i`=6, `sn0`=5, `sn1`=0.
- Contention: after reset, hold `req`=11 for 4 edges.
  - Required: grant sequence 01, 10, 01, 10, then `i`=5, `sn0`=2, `sn1`=2.
- Pointer carry-over: `req`=01 for 2 edges, then `req`=11 for 1 edge.
  - Required: the third grant is 10.
- Exhaustion: after reset, hold `req`=11 for 310 edges.
  - Required: after edge 300, `i`=301, `sn0`=150, `sn1`=150, `exhausted`=1.
  - Required: from edge 301 on, `grant`=00 and all counts frozen.
  - Required: the invariant holds on every edge.
- Clear mid-run: with `req`=11, assert `clear` for one edge when `i`=100.
  - Required: after that edge, `i`=1, `sn0`=`sn1`=0, `grant`=00.
  - Required: the next edge grants 01.

Source files
------------

// File: rtl/bounded_count_arbiter.sv
// bounded_count_arbiter
// Two-requester round-robin arbiter that drives one shared, bounded step
// index. Each grant advances the index and credits the winner's tally.
// Once the index passes LIMIT, no further grants are issued until the
// block is reset or cleared.

module bounded_count_arbiter #(
    parameter int W     = 10,
    parameter int LIMIT = 300
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [1:0]   req,
    output logic [1:0]   grant,
    output logic [W-1:0] i,
    output logic [W-1:0] sn0,
    output logic [W-1:0] sn1,
    output logic         busy,
    output logic         exhausted
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
    localparam logic [W-1:0] ZERO_W  = W'(0);
    localparam logic [W-1:0] ONE_W   = W'(1);

    // Round-robin pointer: the most recent winner. The reset value of 1
    // lets requester 0 win the first tie.
    logic       last_r;
    logic       eligible_s;
    logic       win_s;
    logic [1:0] grant_s;

    // Selects the winner for a given request vector and pointer.
    // A lone requester always wins; a tie goes to the requester that
    // did not win most recently.
    function automatic logic pick_winner(input logic [1:0] r, input logic prev);
        logic w;
        case (r)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = ~prev;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // The index stops at LIMIT+1, so this compare never sees a wrapped value.
    assign exhausted = (i > LIMIT_W);

    // Decides whether this edge grants, and to which requester.
    always_comb begin
        eligible_s = (!exhausted) && (req != 2'b00);
        win_s      = pick_winner(req, last_r);
        grant_s    = 2'b00;
        if (eligible_s) begin
            grant_s = win_s ? 2'b10 : 2'b01;
        end else begin
            grant_s = 2'b00;
        end
    end

    // Updates the index, the tallies, the pointer and the registered
    // grant/busy outputs. A clear acts like a reset taken on the edge and
    // has priority over a simultaneous request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i      <= ONE_W;
            sn0    <= ZERO_W;
            sn1    <= ZERO_W;
            grant  <= 2'b00;
            busy   <= 1'b0;
            last_r <= 1'b1;
        end else if (clear) begin
            i      <= ONE_W;
            sn0    <= ZERO_W;
            sn1    <= ZERO_W;
            grant  <= 2'b00;
            busy   <= 1'b0;
            last_r <= 1'b1;
        end else if (eligible_s) begin
            i      <= i + ONE_W;
            if (win_s) begin
                sn1 <= sn1 + ONE_W;
            end else begin
                sn0 <= sn0 + ONE_W;
            end
            grant  <= grant_s;
            busy   <= 1'b1;
            last_r <= win_s;
        end else begin
            grant  <= 2'b00;
            busy   <= 1'b0;
        end
    end

endmodule
